// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state and write-buffer entry types for the write-buffer drain controller.
package wb_pkg;
  localparam int DATA_LENGTH = 32;
  localparam int TAG_LENGTH = 30;
  typedef enum logic [2:0] {ST_IDLE, ST_POP, ST_CAPT, ST_WREQ, ST_MISS} wb_drain_state_e;
  typedef struct packed {
    logic [TAG_LENGTH-1:0] tag;
    logic [DATA_LENGTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_starve_timer.sv
// wb_starve_timer: saturating count of cycles the buffer waits undrained; expired_o forces one drain.
module wb_starve_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_i,
  input  logic clear_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = cnt_q == W'(TIMEOUT_CYCLES);
  always_comb cnt_d = clear_i ? '0 : (count_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_drain_ctrl.sv
// wb_drain_ctrl: drains the D-cache write buffer onto the memory port and arbitrates it against read-miss fills.
// Define WB_DRAIN_TIMEOUT_EN to force a drain after TIMEOUT_CYCLES of starvation by misses.
module wb_drain_ctrl #(
  parameter int DATA_LENGTH = 32,
  parameter int TAG_LENGTH = 30,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wb_empty,
  input  logic                              wb_full,
  input  logic [TAG_LENGTH+DATA_LENGTH-1:0] wb_data,
  output logic                              wb_load,
  input  logic                              miss_req,
  input  logic [TAG_LENGTH-1:0]             miss_addr,
  input  logic                              miss_wb_hit,
  output logic                              miss_done,
  input  logic                              flush,
  output logic                              flush_done,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [TAG_LENGTH-1:0]             mem_addr,
  output logic [DATA_LENGTH-1:0]            mem_wdata,
  input  logic                              mem_ack
);
  import wb_pkg::*;
  wb_drain_state_e state_q, state_d;
  logic [TAG_LENGTH-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [DATA_LENGTH-1:0] wdata_q, wdata_d;
  logic drain_go, miss_ok, starved;
`ifdef WB_DRAIN_TIMEOUT_EN
  wb_starve_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_i   (!wb_empty && (state_q == ST_MISS || (state_q == ST_IDLE && state_d != ST_POP))),
    .clear_i   (state_q == ST_POP || wb_empty),
    .expired_o (starved)
  );
`else
  assign starved = 1'b0;
`endif
  // A pending miss holds off draining unless the buffer is full, flushing, or holds the miss address.
  assign drain_go = !wb_empty && (wb_full || flush || miss_wb_hit || !miss_req || starved);
  assign miss_ok = miss_req && (wb_empty || !miss_wb_hit);
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = drain_go ? ST_POP : miss_ok ? ST_MISS : ST_IDLE;
      ST_POP:  state_d = ST_CAPT;
      ST_CAPT: state_d = ST_WREQ;
      ST_WREQ: state_d = !mem_ack ? ST_WREQ : drain_go ? ST_POP : ST_IDLE;
      ST_MISS: state_d = mem_ack ? ST_IDLE : ST_MISS;
      default: state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    addr_d = state_q == ST_CAPT ? wb_data[TAG_LENGTH+DATA_LENGTH-1 -: TAG_LENGTH] : addr_q;
    wdata_d = state_q == ST_CAPT ? wb_data[DATA_LENGTH-1:0] : wdata_q;
    maddr_d = (state_q == ST_IDLE && state_d == ST_MISS) ? miss_addr : maddr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
    end
  assign wb_load = state_q == ST_POP;
  assign mem_req = state_q == ST_WREQ || state_q == ST_MISS;
  assign mem_we = state_q == ST_WREQ;
  assign mem_addr = state_q == ST_WREQ ? addr_q : state_q == ST_MISS ? maddr_q : '0;
  assign mem_wdata = state_q == ST_WREQ ? wdata_q : '0;
  assign miss_done = state_q == ST_MISS && mem_ack;
  assign flush_done = flush && wb_empty && state_q == ST_IDLE;
endmodule
